decoder_periph_regs: RTL and testbench
======================================

DECODER_PERIPH_REGS -- requirements
Module: decoder_periph_regs

Interface
REQ-001 Parameter BASE_ADDR, 15'h0190, byte base address; SHALL be aligned to 8*NUM_CH bytes.
REQ-002 Parameter NUM_CH, 2, decoder channel count; SHALL be a power of two, range 1..4.
REQ-003 Parameter RST_HOLD, 16, cycles core reset is held after power-up request (1..255).
REQ-004 Parameter DRAIN_MAX, 1024, maximum cycles waited for cores to go idle at power-down (1..65535).
REQ-005 clk  in  1  single clock for all logic.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 per_addr  in  14  peripheral word address.
REQ-008 per_din  in  16  write data.
REQ-009 per_en  in  1  access strobe.
REQ-010 per_we  in  2  byte write enables; any nonzero value means a full 16-bit write.
REQ-011 per_dout  out  16  read data, combinational; 0 when not selected.
REQ-012 power_control  in  1  power-on request level.
REQ-013 power_ack  out  1  high while cores are powered and released.
REQ-014 core_busy  in  NUM_CH  per-channel core activity.
REQ-015 core_pic_num  in  6*NUM_CH  per-channel picture number; channel n is bits [6n+5:6n].
REQ-016 core_slice_hdr  in  NUM_CH  per-channel slice-header flag.
REQ-017 core_rst  out  NUM_CH  per-channel core reset, active-high.
REQ-018 core_freq_ctrl  out  2*NUM_CH  per-channel frequency select.
REQ-019 core_disable_df  out  NUM_CH  per-channel deblocking-filter disable.
REQ-020 irq  out  1  interrupt request, level, registered.

Function
REQ-021 The block is selected on per_en AND per_addr[13:log2(NUM_CH)+2] == BASE_ADDR[14:log2(NUM_CH)+3].
- Channel index = per_addr[log2(NUM_CH)+1:2].
- Register = per_addr[1:0].
REQ-022 Per-channel register map:
- 0 CTRL, RW: bit0 EN, bits2:1 FREQ, bit3 DIS_DF; other bits read 0.
- 1 STAT, RO: {slice_hdr, busy, 8'b0, pic_num[5:0]}.
- 2 IFG, write-1-to-clear.
- 3 IE, RW, bits2:0.
REQ-023 Writes take effect on the next clk edge. Reads have zero-cycle latency.
REQ-024 IFG flags:
- bit0 sets on any change of the channel's pic_num between consecutive cycles.
- bit1 sets on a rising edge of slice_hdr.
- bit2 sets on a drain timeout, on every channel still busy at timeout.
REQ-025 If an event and a W1C of the same flag occur in the same cycle, the flag SHALL be set.
REQ-026 irq SHALL be the registered OR over all channels of (IFG & IE), one cycle after the flag or enable changes.
REQ-027 Power FSM states and transitions:
- OFF: exits to WAKE when power_control = 1.
- WAKE: a counter runs RST_HOLD cycles, then the FSM moves to ON.
- ON: exits to DRAIN when power_control = 0.
- DRAIN: moves to OFF when core_busy == 0 or when the counter reaches DRAIN_MAX; the latter is a timeout.
REQ-028 power_control dropping during WAKE SHALL return the FSM to OFF immediately. power_control rising during DRAIN SHALL NOT abort the drain.
REQ-029 power_ack SHALL be 1 only in ON and DRAIN.
REQ-030 core_rst[n] SHALL be 1 unless the state is ON or DRAIN and CTRL[n].EN = 1.
REQ-031 core_freq_ctrl and core_disable_df SHALL mirror CTRL fields directly.
REQ-032 Writes to unmapped channels or registers SHALL be ignored; reads of them SHALL return 0.

Reset
REQ-033 On reset, all registers and edge-detect history SHALL clear, the FSM SHALL enter OFF and the counter SHALL clear.
REQ-034 Output values during reset:
- power_ack = 0, irq = 0.
- core_rst = all 1.
- core_freq_ctrl = 0, core_disable_df = 0.
REQ-035 Edge-detect history SHALL load current inputs on the first cycle after reset, so no spurious flags are raised.

Structure
REQ-036 A shared package SHALL hold:
- register offset constants,
- CTRL/IFG bit positions,
- the power FSM state encoding.
REQ-037 The per-channel register set (CTRL, IE, IFG, edge detect) SHALL be one sub-module, decoder_periph_chan, instantiated NUM_CH times.
- The power FSM and the address decoder SHALL stay in the top level.

Verification
REQ-038 Write CTRL ch1 = 16'h000F, then read it back -> per_dout = 16'h000F. Check core_freq_ctrl[3:2] = 2'b11 and core_disable_df[1] = 1.
REQ-039 Set CTRL.EN, raise power_control -> power_ack rises after 16 cycles and core_rst goes to 0 in the same cycle. Drop power_control with busy = 0 -> OFF on the next edge.
REQ-040 Enter DRAIN with core_busy[0] stuck at 1 -> timeout after 1024 cycles: IFG0 bit2 = 1, OFF reached, and irq = 1 when IE0 bit2 = 1.
REQ-041 Change pic_num on ch0 from 5 to 6 in the same cycle as a W1C of IFG0 bit0 -> the flag stays 1.
REQ-042 Assert reset mid-WAKE -> next cycle shows OFF, all core_rst = 1, all registers = 0, and no flags are set afterward.

Source files
------------

// File: rtl/decoder_periph_regs_pkg.sv
// Shared constants for the decoder peripheral register block: register offsets,
// CTRL/IFG bit positions and the power sequencer state encoding.
package decoder_periph_regs_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_IFG  = 2'd2;
  localparam logic [1:0] REG_IE   = 2'd3;

  localparam int CTRL_W       = 4;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_FREQ_LO = 1;
  localparam int CTRL_FREQ_HI = 2;
  localparam int CTRL_DIS_DF  = 3;

  localparam int IFG_W     = 3;
  localparam int IFG_PIC   = 0;
  localparam int IFG_SLICE = 1;
  localparam int IFG_TMO   = 2;

  localparam logic [1:0] PWR_OFF   = 2'd0;
  localparam logic [1:0] PWR_WAKE  = 2'd1;
  localparam logic [1:0] PWR_ON    = 2'd2;
  localparam logic [1:0] PWR_DRAIN = 2'd3;

  typedef struct packed {
    logic       dis_df;
    logic [1:0] freq;
    logic       en;
  } ctrl_t;

  function automatic logic pwr_is_up(input logic [1:0] st);
    return (st == PWR_ON) || (st == PWR_DRAIN);
  endfunction

endpackage

// File: rtl/decoder_periph_regs_chan.sv
// One decoder channel's register set: CTRL, IE, W1C IFG and the input edge
// detectors feeding IFG, plus its slice of the read mux.
module decoder_periph_chan
  import decoder_periph_regs_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en_i,
  input  logic [1:0]  reg_sel_i,
  input  logic [3:0]  wdata_i,
  input  logic [5:0]  pic_num_i,
  input  logic        slice_hdr_i,
  input  logic        busy_i,
  input  logic        tmo_evt_i,
  output logic [15:0] rd_data_o,
  output logic [3:0]  ctrl_o,
  output logic        irq_req_o
);

  ctrl_t            ctrl_q, ctrl_d;
  logic [IFG_W-1:0] ie_q, ie_d;
  logic [IFG_W-1:0] ifg_q, ifg_d;
  logic [IFG_W-1:0] evt;
  logic [5:0]       pic_q;
  logic             slice_q;
  logic             hist_vld_q;

  always_comb begin
    ctrl_d = ctrl_q;
    ie_d   = ie_q;
    if (wr_en_i && (reg_sel_i == REG_CTRL)) ctrl_d = ctrl_t'(wdata_i);
    if (wr_en_i && (reg_sel_i == REG_IE))   ie_d   = wdata_i[IFG_W-1:0];

    // History is only trusted once it has captured one real sample after reset.
    evt            = '0;
    evt[IFG_PIC]   = hist_vld_q && (pic_num_i != pic_q);
    evt[IFG_SLICE] = hist_vld_q && slice_hdr_i && !slice_q;
    evt[IFG_TMO]   = tmo_evt_i;

    ifg_d = ifg_q;
    if (wr_en_i && (reg_sel_i == REG_IFG)) ifg_d = ifg_q & ~wdata_i[IFG_W-1:0];
    ifg_d = ifg_d | evt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      ie_q       <= '0;
      ifg_q      <= '0;
      pic_q      <= '0;
      slice_q    <= 1'b0;
      hist_vld_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      ie_q       <= ie_d;
      ifg_q      <= ifg_d;
      pic_q      <= pic_num_i;
      slice_q    <= slice_hdr_i;
      hist_vld_q <= 1'b1;
    end
  end

  always_comb begin
    rd_data_o = '0;
    case (reg_sel_i)
      REG_CTRL: rd_data_o[CTRL_W-1:0] = ctrl_q;
      REG_STAT: rd_data_o = {slice_hdr_i, busy_i, 8'b0, pic_num_i};
      REG_IFG:  rd_data_o[IFG_W-1:0] = ifg_q;
      default:  rd_data_o[IFG_W-1:0] = ie_q;
    endcase
  end

  assign ctrl_o    = ctrl_q;
  assign irq_req_o = |(ifg_q & ie_q);

endmodule

// File: rtl/decoder_periph_regs.sv
// Decoder peripheral register block: address decode, per-channel register
// sets and the power sequencer that gates the per-core resets.
module decoder_periph_regs
  import decoder_periph_regs_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0190,
  parameter int          NUM_CH    = 2,
  parameter int          RST_HOLD  = 16,
  parameter int          DRAIN_MAX = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [13:0]           per_addr,
  input  logic [15:0]           per_din,
  input  logic                  per_en,
  input  logic [1:0]            per_we,
  output logic [15:0]           per_dout,
  input  logic                  power_control,
  output logic                  power_ack,
  input  logic [NUM_CH-1:0]     core_busy,
  input  logic [6*NUM_CH-1:0]   core_pic_num,
  input  logic [NUM_CH-1:0]     core_slice_hdr,
  output logic [NUM_CH-1:0]     core_rst,
  output logic [2*NUM_CH-1:0]   core_freq_ctrl,
  output logic [NUM_CH-1:0]     core_disable_df,
  output logic                  irq
);

  localparam int          CH_LOG2    = $clog2(NUM_CH);
  localparam int          IDX_W      = (CH_LOG2 == 0) ? 1 : CH_LOG2;
  localparam logic [15:0] HOLD_LAST  = 16'(RST_HOLD - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_MAX - 1);

  logic             blk_sel;
  logic             wr_req;
  logic [IDX_W-1:0] chan_idx;
  logic [1:0]       reg_sel;
  logic             unused_din;

  assign blk_sel    = per_en && (per_addr[13:CH_LOG2+2] == BASE_ADDR[14:CH_LOG2+3]);
  assign wr_req     = blk_sel && (per_we != 2'b00);
  // With a single channel the index field is empty; masking pins it to zero.
  assign chan_idx   = per_addr[IDX_W+1:2] & IDX_W'(NUM_CH - 1);
  assign reg_sel    = per_addr[1:0];
  assign unused_din = ^per_din[15:CTRL_W];

  logic [1:0]  pwr_q, pwr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        drain_tmo;
  logic        pwr_up;

  assign drain_tmo = (pwr_q == PWR_DRAIN) && (core_busy != '0) && (cnt_q == DRAIN_LAST);
  assign pwr_up    = pwr_is_up(pwr_q);

  always_comb begin
    pwr_d = pwr_q;
    cnt_d = cnt_q;
    case (pwr_q)
      PWR_OFF: begin
        if (power_control) begin
          pwr_d = PWR_WAKE;
          cnt_d = '0;
        end
      end
      PWR_WAKE: begin
        if (!power_control) begin
          pwr_d = PWR_OFF;
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          pwr_d = PWR_ON;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      PWR_ON: begin
        if (!power_control) begin
          pwr_d = PWR_DRAIN;
          cnt_d = '0;
        end
      end
      default: begin
        // A renewed power request cannot abort the drain; only idle or timeout ends it.
        if ((core_busy == '0) || drain_tmo) begin
          pwr_d = PWR_OFF;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwr_q <= PWR_OFF;
      cnt_q <= '0;
    end else begin
      pwr_q <= pwr_d;
      cnt_q <= cnt_d;
    end
  end

  logic [15:0]       chan_rd [NUM_CH];
  logic [NUM_CH-1:0] chan_irq;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      logic [3:0] ctrl;

      decoder_periph_chan u_chan (
        .clk         (clk),
        .reset       (reset),
        .wr_en_i     (wr_req && (chan_idx == IDX_W'(gi))),
        .reg_sel_i   (reg_sel),
        .wdata_i     (per_din[CTRL_W-1:0]),
        .pic_num_i   (core_pic_num[6*gi +: 6]),
        .slice_hdr_i (core_slice_hdr[gi]),
        .busy_i      (core_busy[gi]),
        .tmo_evt_i   (drain_tmo && core_busy[gi]),
        .rd_data_o   (chan_rd[gi]),
        .ctrl_o      (ctrl),
        .irq_req_o   (chan_irq[gi])
      );

      assign core_rst[gi]            = reset || !(pwr_up && ctrl[CTRL_EN]);
      assign core_freq_ctrl[2*gi +: 2] = reset ? 2'b00 : ctrl[CTRL_FREQ_HI:CTRL_FREQ_LO];
      assign core_disable_df[gi]     = !reset && ctrl[CTRL_DIS_DF];
    end
  endgenerate

  assign per_dout  = blk_sel ? chan_rd[chan_idx] : 16'h0000;
  assign power_ack = pwr_up && !reset;

  logic irq_q;

  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= |chan_irq;
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_decoder_periph_regs.sv
// Self-checking bench for decoder_periph_regs: register reads go through a
// scoreboard queue, power/irq behaviour is checked against bench constants.
module tb_decoder_periph_regs;

  localparam logic [13:0] BASE_W = 14'h00C8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] per_addr = '0;
  logic [15:0] per_din = '0;
  logic        per_en = 1'b0;
  logic [1:0]  per_we = 2'b00;
  logic [15:0] per_dout;
  logic        power_control = 1'b0;
  logic        power_ack;
  logic [1:0]  core_busy = 2'b00;
  logic [11:0] core_pic_num = {6'd9, 6'd5};
  logic [1:0]  core_slice_hdr = 2'b00;
  logic [1:0]  core_rst;
  logic [3:0]  core_freq_ctrl;
  logic [1:0]  core_disable_df;
  logic        irq;

  always #50 clk = ~clk;

  decoder_periph_regs #(
    .BASE_ADDR (15'h0190),
    .NUM_CH    (2),
    .RST_HOLD  (16),
    .DRAIN_MAX (1024)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .per_addr        (per_addr),
    .per_din         (per_din),
    .per_en          (per_en),
    .per_we          (per_we),
    .per_dout        (per_dout),
    .power_control   (power_control),
    .power_ack       (power_ack),
    .core_busy       (core_busy),
    .core_pic_num    (core_pic_num),
    .core_slice_hdr  (core_slice_hdr),
    .core_rst        (core_rst),
    .core_freq_ctrl  (core_freq_ctrl),
    .core_disable_df (core_disable_df),
    .irq             (irq)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] sb_data[$];
  string       sb_tag[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] ra(input int ch, input int r);
    return BASE_W + 14'(ch * 4) + 14'(r);
  endfunction

  task automatic wr(input logic [13:0] a, input logic [15:0] d, input logic [1:0] we = 2'b11);
    per_addr = a;
    per_din  = d;
    per_we   = we;
    per_en   = 1'b1;
    tick();
    per_en   = 1'b0;
    per_we   = 2'b00;
  endtask

  task automatic rd(input string tag, input logic [13:0] a, input logic [15:0] exp);
    sb_data.push_back(exp);
    sb_tag.push_back(tag);
    per_addr = a;
    per_we   = 2'b00;
    per_en   = 1'b1;
    #1;
    check(sb_tag.pop_front(), {16'h0, per_dout}, {16'h0, sb_data.pop_front()});
    per_en = 1'b0;
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset values
    repeat (3) tick();
    check("rst_power_ack", power_ack, 0);
    check("rst_core_rst", core_rst, 2'b11);
    check("rst_freq", core_freq_ctrl, 4'b0000);
    check("rst_dis_df", core_disable_df, 2'b00);
    check("rst_irq", irq, 0);
    reset = 1'b0;
    repeat (2) tick();
    rd("ctrl0_rst", ra(0, 0), 16'h0000);
    rd("ifg0_no_spurious", ra(0, 2), 16'h0000);
    rd("ifg1_no_spurious", ra(1, 2), 16'h0000);

    // CTRL write/readback, partial byte enable counts as a full write
    wr(ra(1, 0), 16'h000F, 2'b10);
    rd("ctrl1_rdback", ra(1, 0), 16'h000F);
    check("freq_ch1", core_freq_ctrl[3:2], 2'b11);
    check("dis_df_ch1", core_disable_df[1], 1);
    check("freq_all", core_freq_ctrl, 4'b1100);
    check("core_rst_off", core_rst, 2'b11);
    wr(ra(1, 0), 16'hFFFF);
    rd("ctrl1_mask", ra(1, 0), 16'h000F);
    rd("unsel_above", BASE_W + 14'd8, 16'h0000);
    rd("unsel_below", BASE_W - 14'd1, 16'h0000);

    // STAT reflects live inputs
    core_busy = 2'b01;
    rd("stat0", ra(0, 1), 16'h4005);
    rd("stat1", ra(1, 1), 16'h0009);
    core_busy = 2'b00;

    // IE mask, slice-header flag and irq latency
    wr(ra(1, 3), 16'hFFFF);
    rd("ie1_mask", ra(1, 3), 16'h0007);
    check("irq_idle", irq, 0);
    core_slice_hdr[1] = 1'b1;
    tick();
    check("irq_lag", irq, 0);
    rd("ifg1_slice", ra(1, 2), 16'h0002);
    rd("stat1_slice", ra(1, 1), 16'h8009);
    tick();
    check("irq_set", irq, 1);
    wr(ra(1, 2), 16'h0002);
    rd("ifg1_w1c", ra(1, 2), 16'h0000);
    tick();
    check("irq_clr", irq, 0);

    // pic_num change collides with W1C of the same flag
    core_pic_num[5:0] = 6'd6;
    wr(ra(0, 2), 16'h0001);
    rd("ifg0_evt_wins", ra(0, 2), 16'h0001);
    wr(ra(0, 2), 16'h0001);
    rd("ifg0_w1c_only", ra(0, 2), 16'h0000);

    // Power-up sequence
    wr(ra(0, 0), 16'h0001);
    per_addr = ra(0, 0);
    #1;
    check("dout_no_en", per_dout, 16'h0000);
    power_control = 1'b1;
    tick();
    check("wake_ack", power_ack, 0);
    check("wake_core_rst", core_rst, 2'b11);
    n = 0;
    while (!power_ack && n < 40) begin
      tick();
      n++;
    end
    check("wake_cycles", n, 16);
    check("on_core_rst", core_rst, 2'b00);
    wr(ra(1, 0), 16'h000E);
    check("on_ch1_disabled", core_rst, 2'b10);

    // Power-down with idle cores
    power_control = 1'b0;
    tick();
    check("drain_ack", power_ack, 1);
    tick();
    check("off_ack", power_ack, 0);
    check("off_core_rst", core_rst, 2'b11);

    // Abort during WAKE
    power_control = 1'b1;
    repeat (6) tick();
    power_control = 1'b0;
    tick();
    check("wake_abort_ack", power_ack, 0);
    repeat (20) tick();
    check("wake_abort_stays_off", power_ack, 0);
    power_control = 1'b1;
    tick();
    n = 0;
    while (!power_ack && n < 40) begin
      tick();
      n++;
    end
    check("wake_cycles_again", n, 16);

    // Drain timeout with ch0 stuck busy
    wr(ra(0, 3), 16'h0004);
    core_busy = 2'b01;
    power_control = 1'b0;
    tick();
    check("drain_entry", power_ack, 1);
    n = 0;
    while (power_ack && n < 1100) begin
      if (n == 100) power_control = 1'b1;
      if (n == 200) power_control = 1'b0;
      tick();
      n++;
    end
    check("drain_timeout_cycles", n, 1024);
    rd("ifg0_timeout", ra(0, 2), 16'h0004);
    rd("ifg1_no_timeout", ra(1, 2), 16'h0000);
    tick();
    check("irq_timeout", irq, 1);
    check("tmo_core_rst", core_rst, 2'b11);
    core_busy = 2'b00;

    // Reset in the middle of WAKE
    wr(ra(0, 0), 16'h000B);
    power_control = 1'b1;
    repeat (6) tick();
    core_pic_num[5:0] = 6'd20;
    core_slice_hdr[0] = 1'b1;
    reset = 1'b1;
    tick();
    check("mid_rst_ack", power_ack, 0);
    check("mid_rst_core_rst", core_rst, 2'b11);
    check("mid_rst_freq", core_freq_ctrl, 4'b0000);
    check("mid_rst_irq", irq, 0);
    reset = 1'b0;
    power_control = 1'b0;
    repeat (3) tick();
    check("post_rst_ack", power_ack, 0);
    check("post_rst_dis_df", core_disable_df, 2'b00);
    rd("post_ctrl0", ra(0, 0), 16'h0000);
    rd("post_ctrl1", ra(1, 0), 16'h0000);
    rd("post_ie0", ra(0, 3), 16'h0000);
    rd("post_ie1", ra(1, 3), 16'h0000);
    rd("post_ifg0", ra(0, 2), 16'h0000);
    rd("post_ifg1", ra(1, 2), 16'h0000);
    check("post_irq", irq, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
